// File: rtl/cv32e40p_trace_buffer.sv
// Multi-channel trace capture buffer: round-robin arbiter feeding one FIFO, stall or drop on full.
// Optional macro CV32E40P_TRACE_TIMESTAMP_EN prepends a 32-bit cycle stamp to each record.
module cv32e40p_trace_buffer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16,
  parameter int STALL_MODE = 1,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW        = $clog2(DEPTH),
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
  localparam int OUT_W     = DATA_W + 32
`else
  localparam int OUT_W     = DATA_W
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OUT_W-1:0]         out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic [AW:0]              level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o
);

  localparam int SW = CNT_W + 5;

  logic [OUT_W-1:0]  mem [DEPTH];
  logic [CH_W-1:0]   ch_mem [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic [CH_W-1:0]   rr_ptr, rr_next, gsel;
  logic              gany, live, full, empty, push, pop, drop;
  logic [SW-1:0]     pc, sum;
  logic [CNT_W-1:0]  drop_nxt;
  logic [OUT_W-1:0]  wr_word;

  assign live  = enable_i && !clear_i && !rst_i;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Search starts at the round-robin pointer and wraps around the channel set.
  always_comb begin
    int idx;
    idx     = 0;
    gany    = 1'b0;
    gsel    = '0;
    rr_next = rr_ptr;
    if (live) begin
      for (int i = 0; i < NUM_CH; i++) begin
        idx = (int'(rr_ptr) + i) % NUM_CH;
        if (!gany && ch_valid_i[idx]) begin
          gany = 1'b1;
          gsel = CH_W'(idx);
        end
      end
    end
    if (gany) rr_next = CH_W'((int'(gsel) + 1) % NUM_CH);
  end

  always_comb begin
    ch_ready_o = '0;
    drop       = 1'b0;
    if (STALL_MODE != 0) begin
      if (gany && !full) ch_ready_o[gsel] = 1'b1;
    end else if (full) begin
      if (live) ch_ready_o = ch_valid_i;
      drop = live && (|ch_valid_i);
    end else if (gany) begin
      ch_ready_o[gsel] = 1'b1;
    end
  end

  assign push = gany && !full;
  assign pop  = !empty && out_ready_i && !clear_i;

  always_comb begin
    pc = '0;
    for (int k = 0; k < NUM_CH; k++) pc = pc + SW'(ch_valid_i[k]);
    sum = SW'(drop_cnt_o) + pc;
    if (sum > SW'({CNT_W{1'b1}})) drop_nxt = '1;
    else                          drop_nxt = sum[CNT_W-1:0];
  end

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
  logic [31:0] ts;
  always_ff @(posedge clk_i) begin
    if (rst_i) ts <= '0;
    else       ts <= ts + 32'd1;
  end
  assign wr_word = {ts, ch_data_i[gsel*DATA_W +: DATA_W]};
`else
  assign wr_word = ch_data_i[gsel*DATA_W +: DATA_W];
`endif

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr[AW-1:0]]    <= wr_word;
      ch_mem[wptr[AW-1:0]] <= gsel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr       <= '0;
      rptr       <= '0;
      rr_ptr     <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      rr_ptr <= rr_next;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) begin
        drop_cnt_o <= drop_nxt;
        overflow_o <= 1'b1;
      end
    end
  end

  assign out_valid_o = !empty;
  assign out_data_o  = mem[rptr[AW-1:0]];
  assign out_ch_o    = ch_mem[rptr[AW-1:0]];
  assign level_o     = wptr - rptr;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Directed bench: one stall-mode and one drop-mode instance share stimulus.
module tb_cv32e40p_trace_buffer;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
  localparam int OUT_W = 96;
`else
  localparam int OUT_W = 64;
`endif

  logic         clk = 1'b0;
  logic         rst, en, clr, ordy;
  logic [3:0]   valid;
  logic [255:0] data;
  logic [3:0]   rdy_s, rdy_d;
  logic         ov_s, ov_d, of_s, of_d;
  logic [OUT_W-1:0] od_s, od_d;
  logic [1:0]   och_s, och_d;
  logic [4:0]   lvl_s, lvl_d;
  logic [15:0]  dc_s, dc_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_trace_buffer #(.NUM_CH(4), .DATA_W(64), .DEPTH(16), .STALL_MODE(1), .CNT_W(16)) dut_s (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .ch_valid_i(valid), .ch_ready_o(rdy_s),
    .ch_data_i(data), .out_valid_o(ov_s), .out_ready_i(ordy), .out_data_o(od_s), .out_ch_o(och_s),
    .level_o(lvl_s), .drop_cnt_o(dc_s), .overflow_o(of_s));

  cv32e40p_trace_buffer #(.NUM_CH(4), .DATA_W(64), .DEPTH(16), .STALL_MODE(0), .CNT_W(16)) dut_d (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .ch_valid_i(valid), .ch_ready_o(rdy_d),
    .ch_data_i(data), .out_valid_o(ov_d), .out_ready_i(ordy), .out_data_o(od_d), .out_ch_o(och_d),
    .level_o(lvl_d), .drop_cnt_o(dc_d), .overflow_o(of_d));

  typedef struct {
    logic [3:0] valid;
    logic       en;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] och;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [63:0] v);
    data[k*64 +: 64] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = '0; clr = 1'b0; ordy = 1'b0; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] base;
    int pushed, rcv;

    tv[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tv[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tv[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tv[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tv[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    tv[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0};
    tv[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2};
    tv[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    tv[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 2'd0};
    tv[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3};
    tv[10] = '{4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0};
    tv[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1};

    rst = 1'b1; en = 1'b1; clr = 1'b0; ordy = 1'b0; valid = 4'b1111; data = '0;
    for (int k = 0; k < 4; k++) set_ch(k, 64'hA5A5_0000_0000_0000 | 64'(k));
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready_s", 64'(rdy_s), 64'd0);
    chk("rst_ready_d", 64'(rdy_d), 64'd0);
    chk("rst_level", 64'(lvl_s), 64'd0);
    chk("rst_valid", 64'(ov_s), 64'd0);
    chk("rst_drop", 64'(dc_d), 64'd0);
    chk("rst_ovf", 64'(of_d), 64'd0);
    rst = 1'b0; valid = '0; ordy = 1'b1;

    // Arbiter rotation table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid = tv[i].valid; en = tv[i].en;
      #1;
      chk($sformatf("rr_ready_s[%0d]", i), 64'(rdy_s), 64'(tv[i].rdy));
      chk($sformatf("rr_ready_d[%0d]", i), 64'(rdy_d), 64'(tv[i].rdy));
      chk($sformatf("rr_ovalid[%0d]", i), 64'(ov_s), 64'(tv[i].ov));
      if (tv[i].ov) begin
        chk($sformatf("rr_och[%0d]", i), 64'(och_s), 64'(tv[i].och));
        chk($sformatf("rr_data[%0d]", i), od_s[63:0], 64'hA5A5_0000_0000_0000 | 64'(tv[i].och));
      end
    end
    en = 1'b1;

    // Single ch2 push
    do_reset();
    set_ch(2, 64'hDEAD_BEEF); valid = 4'b0100;
    #1 chk("single_ready", 64'(rdy_s), 64'b0100);
    @(negedge clk); valid = '0; #1;
    chk("single_valid", 64'(ov_s), 64'd1);
    chk("single_data", od_s[63:0], 64'hDEAD_BEEF);
    chk("single_ch", 64'(och_s), 64'd2);
    chk("single_level", 64'(lvl_s), 64'd1);

    // Fill with sink stalled
    do_reset();
    base = 64'h1234_0000_0000_0000; pushed = 0; valid = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      set_ch(0, base + 64'(pushed));
      #1 if (rdy_s[0]) pushed++;
      @(negedge clk);
    end
    set_ch(0, base + 64'(pushed)); #1;
    chk("fill_pushed", 64'(pushed), 64'd16);
    chk("fill_level_s", 64'(lvl_s), 64'd16);
    chk("fill_ready_s", 64'(rdy_s), 64'd0);
    chk("fill_drop_s", 64'(dc_s), 64'd0);
    chk("fill_level_d", 64'(lvl_d), 64'd16);
    chk("fill_drop_d", 64'(dc_d), 64'd4);
    chk("fill_ovf_d", 64'(of_d), 64'd1);
    chk("fill_head", od_s[63:0], base);

    // Full, three channels valid
    valid = 4'b0111; #1;
    chk("full3_ready_d", 64'(rdy_d), 64'b0111);
    chk("full3_ready_s", 64'(rdy_s), 64'd0);
    @(negedge clk); #1;
    chk("full3_drop_d", 64'(dc_d), 64'd7);
    chk("full3_level_d", 64'(lvl_d), 64'd16);
    chk("full3_drop_s", 64'(dc_s), 64'd0);

    // Full, push and pop together
    valid = 4'b0001; ordy = 1'b1; #1;
    chk("fpp_ready_s", 64'(rdy_s), 64'd0);
    chk("fpp_ready_d", 64'(rdy_d), 64'b0001);
    chk("fpp_head", od_s[63:0], base);
    @(negedge clk); #1;
    chk("fpp_level_s", 64'(lvl_s), 64'd15);
    chk("fpp_level_d", 64'(lvl_d), 64'd15);
    chk("fpp_drop_d", 64'(dc_d), 64'd8);

    // Drain: all 20 records in order
    rcv = 1;
    for (int c = 0; c < 100 && rcv < 20; c++) begin
      set_ch(0, base + 64'(pushed));
      valid = (pushed < 20) ? 4'b0001 : 4'b0000;
      #1;
      if (ov_s) begin
        chk($sformatf("drain_data[%0d]", rcv), od_s[63:0], base + 64'(rcv));
        rcv++;
      end
      if (rdy_s[0]) pushed++;
      @(negedge clk);
    end
    valid = '0; #1;
    chk("drain_count", 64'(rcv), 64'd20);
    chk("drain_empty", 64'(ov_s), 64'd0);

    // Clear with 5 entries and nonzero drops
    ordy = 1'b0; valid = 4'b0001;
    repeat (5) @(negedge clk);
    valid = '0; #1;
    chk("pre_clear_level", 64'(lvl_s), 64'd5);
    clr = 1'b1; valid = 4'b1111; ordy = 1'b1; #1;
    chk("clear_ready_s", 64'(rdy_s), 64'd0);
    chk("clear_ready_d", 64'(rdy_d), 64'd0);
    @(negedge clk); clr = 1'b0; valid = '0; ordy = 1'b0; #1;
    chk("clear_level_s", 64'(lvl_s), 64'd0);
    chk("clear_valid_s", 64'(ov_s), 64'd0);
    chk("clear_level_d", 64'(lvl_d), 64'd0);
    chk("clear_drop_d", 64'(dc_d), 64'd0);
    chk("clear_ovf_d", 64'(of_d), 64'd0);
    valid = 4'b1111; #1;
    chk("clear_rr", 64'(rdy_s), 64'b0001);
    @(negedge clk);

    // Mid-operation reset
    rst = 1'b1; #1;
    chk("midrst_ready", 64'(rdy_s), 64'd0);
    @(negedge clk); rst = 1'b0; valid = '0; #1;
    chk("midrst_level", 64'(lvl_s), 64'd0);
    chk("midrst_valid", 64'(ov_s), 64'd0);
    chk("midrst_drop_d", 64'(dc_d), 64'd0);

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    do_reset();
    repeat (10) @(negedge clk);
    set_ch(2, 64'h0000_0000_CAFE_F00D); valid = 4'b0100;
    @(negedge clk); valid = '0; #1;
    chk("ts_value", 64'(od_s[95:64]), 64'd10);
    chk("ts_record", od_s[63:0], 64'h0000_0000_CAFE_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
